// File: rtl/term_flag_encoder8_pkg.sv
// Shared constants, state type and helper function for the term-flag encoder.
// Optional feature macro used by this block: TERM_ENC_COUNT_EN.
package term_enc_pkg;

    localparam int N     = 8;
    localparam int IDX_W = $clog2(N);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Number of set bits in an 8-bit vector, 0..8
    function automatic logic [IDX_W:0] popcount8(input logic [N-1:0] v);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/term_flag_encoder8_if.sv
// Load and index-stream handshake bundle of the term-flag encoder.
// The slave side is the encoder; the master side feeds vectors and consumes indices.
interface term_flag_encoder8_if;
    import term_enc_pkg::*;

    logic [N-1:0]     flags_in;
    logic             load_valid;
    logic             load_ready;
    logic [IDX_W-1:0] idx_out;
    logic             idx_valid;
    logic             idx_ready;
    logic             idx_last;

    modport master (
        output flags_in,
        output load_valid,
        input  load_ready,
        input  idx_out,
        input  idx_valid,
        output idx_ready,
        input  idx_last
    );

    modport slave (
        input  flags_in,
        input  load_valid,
        output load_ready,
        output idx_out,
        output idx_valid,
        input  idx_ready,
        output idx_last
    );

endinterface

// File: rtl/term_flag_encoder8_lsb.sv
// Combinational find-first-set over an 8-bit mask, lowest index wins.
// Also flags whether any bit is set and whether exactly one bit is set.
module lsb_priority_enc8
    import term_enc_pkg::*;
(
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             single
);

    logic [N-1:0] w_lowCleared;

    // Scan from the top down so the lowest set bit is the last to write idx
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero exactly when one bit was set
    assign w_lowCleared = mask & (mask - 8'd1);
    assign any          = |mask;
    assign single       = any && (w_lowCleared == '0);

endmodule

// File: rtl/term_flag_encoder8.sv
// Term-flag encoder: captures an 8-bit sticky flag vector and drains it as a
// stream of slot indices, lowest first, one per accepted beat.
// Optional macro TERM_ENC_COUNT_EN adds term_cnt, the popcount of the loaded vector.
module term_flag_encoder8
    import term_enc_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    term_flag_encoder8_if.slave    bus,
    output logic                   empty_done,
    output logic                   busy
`ifdef TERM_ENC_COUNT_EN
    ,
    output logic [IDX_W:0]         term_cnt
`endif
);

    state_t           r_state;
    logic [N-1:0]     r_pending;

    logic             w_load;
    logic             w_beat;
    logic [N-1:0]     w_beatMask;
    logic [N-1:0]     w_encIn;
    logic [IDX_W-1:0] w_nextIdx;
    logic             w_nextAny;
    logic             w_nextSingle;

    assign bus.load_ready = (r_state == IDLE);
    assign busy           = (r_state == DRAIN);
    assign w_load         = bus.load_valid && bus.load_ready;
    assign w_beat         = bus.idx_valid && bus.idx_ready;
    assign w_beatMask     = w_beat ? (8'd1 << bus.idx_out) : '0;

    // While idle the encoder looks at the incoming vector so the first index
    // is ready one cycle after the load; while draining it looks at what is
    // left once the current beat's bit is removed.
    assign w_encIn = (r_state == IDLE) ? bus.flags_in : (r_pending & ~w_beatMask);

    lsb_priority_enc8 u_enc (
        .mask   (w_encIn),
        .idx    (w_nextIdx),
        .any    (w_nextAny),
        .single (w_nextSingle)
    );

    // FSM, pending bits and registered index outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_pending     <= '0;
            bus.idx_out   <= '0;
            bus.idx_valid <= 1'b0;
            bus.idx_last  <= 1'b0;
            empty_done    <= 1'b0;
        end else begin
            empty_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_pending <= bus.flags_in;
                        if (w_nextAny) begin
                            r_state       <= DRAIN;
                            bus.idx_valid <= 1'b1;
                            bus.idx_out   <= w_nextIdx;
                            bus.idx_last  <= w_nextSingle;
                        end else begin
                            empty_done <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_beat) begin
                        r_pending <= w_encIn;
                        if (w_nextAny) begin
                            bus.idx_out  <= w_nextIdx;
                            bus.idx_last <= w_nextSingle;
                        end else begin
                            r_state       <= IDLE;
                            bus.idx_valid <= 1'b0;
                            bus.idx_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef TERM_ENC_COUNT_EN
    // Term count is captured with the vector and held through the drain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            term_cnt <= '0;
        end else if (w_load) begin
            term_cnt <= popcount8(bus.flags_in);
        end
    end
`endif

endmodule

// File: tb/tb_term_flag_encoder8.sv
// Directed self-checking bench for term_flag_encoder8.
// term_cnt checks are compiled in only when TERM_ENC_COUNT_EN is defined.
module tb_term_flag_encoder8;
    import term_enc_pkg::*;

    logic clk;
    logic reset_n;
    logic emptyDone;
    logic busy;
`ifdef TERM_ENC_COUNT_EN
    logic [IDX_W:0] termCnt;
`endif

    int nCompared;
    int nMismatched;

    term_flag_encoder8_if bus ();

    term_flag_encoder8 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .empty_done (emptyDone),
        .busy       (busy)
`ifdef TERM_ENC_COUNT_EN
        ,
        .term_cnt   (termCnt)
`endif
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Check the full index beat presented after the most recent edge
    task automatic checkBeat(input string tag, input logic [IDX_W-1:0] expIdx, input logic expLast);
        checkOutput({tag, " valid"}, 32'(bus.idx_valid), 32'd1);
        checkOutput({tag, " idx"},   32'(bus.idx_out),   32'(expIdx));
        checkOutput({tag, " last"},  32'(bus.idx_last),  32'(expLast));
        checkOutput({tag, " busy"},  32'(busy),          32'd1);
        checkOutput({tag, " ready"}, 32'(bus.load_ready), 32'd0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " valid"}, 32'(bus.idx_valid),  32'd0);
        checkOutput({tag, " ready"}, 32'(bus.load_ready), 32'd1);
        checkOutput({tag, " busy"},  32'(busy),           32'd0);
    endtask

    // Present a vector for exactly one edge
    task automatic loadVector(input logic [7:0] v);
        bus.flags_in   = v;
        bus.load_valid = 1'b1;
        applyStimulus();
        bus.load_valid = 1'b0;
    endtask

    initial begin
        nCompared      = 0;
        nMismatched    = 0;
        reset_n        = 1'b0;
        bus.flags_in   = 8'h55;
        bus.load_valid = 1'b1;
        bus.idx_ready  = 1'b1;

        // 1. Reset held for two edges with load_valid asserted
        applyStimulus();
        applyStimulus();
        checkIdle("reset");
        checkOutput("reset empty", 32'(emptyDone), 32'd0);
        checkOutput("reset idx", 32'(bus.idx_out), 32'd0);
        bus.load_valid = 1'b0;
        reset_n        = 1'b1;
        applyStimulus();
        checkIdle("post-reset");

        // 2. 0x29 drains as 0,3,5
        bus.idx_ready = 1'b1;
        loadVector(8'h29);
        checkBeat("v29 b0", 3'd0, 1'b0);
        applyStimulus();
        checkBeat("v29 b1", 3'd3, 1'b0);
        applyStimulus();
        checkBeat("v29 b2", 3'd5, 1'b1);
        applyStimulus();
        checkIdle("v29 done");

        // 3. 0x81 with a three-cycle stall on the first index
        bus.idx_ready = 1'b0;
        loadVector(8'h81);
        checkBeat("v81 b0", 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkBeat("v81 stall", 3'd0, 1'b0);
        end
        bus.idx_ready = 1'b1;
        applyStimulus();
        checkBeat("v81 b1", 3'd7, 1'b1);
        applyStimulus();
        checkIdle("v81 done");

        // 4. All-zero vector pulses empty_done once and emits nothing
        loadVector(8'h00);
        checkOutput("zero empty", 32'(emptyDone), 32'd1);
        checkIdle("zero t1");
`ifdef TERM_ENC_COUNT_EN
        checkOutput("zero cnt", 32'(termCnt), 32'd0);
`endif
        applyStimulus();
        checkOutput("zero empty off", 32'(emptyDone), 32'd0);
        checkIdle("zero t2");

        // 5. Reset in the middle of a full drain, then a fresh load
        loadVector(8'hFF);
        checkBeat("vFF r b0", 3'd0, 1'b0);
        applyStimulus();
        checkBeat("vFF r b1", 3'd1, 1'b0);
        applyStimulus();
        checkBeat("vFF r b2", 3'd2, 1'b0);
        applyStimulus();
        checkBeat("vFF r b3", 3'd3, 1'b0);
        reset_n = 1'b0;
        applyStimulus();
        checkIdle("abort");
        reset_n = 1'b1;
        loadVector(8'h10);
        checkBeat("v10 b0", 3'd4, 1'b1);
        applyStimulus();
        checkIdle("v10 done");

        // 6. Full vector, with load_valid poked during the drain
        loadVector(8'hFF);
        for (int i = 0; i < 8; i++) begin
            checkBeat("vFF", IDX_W'(i), (i == 7));
`ifdef TERM_ENC_COUNT_EN
            checkOutput("vFF cnt", 32'(termCnt), 32'd8);
`endif
            bus.flags_in   = 8'h01;
            bus.load_valid = (i >= 1 && i <= 6);
            applyStimulus();
        end
        bus.load_valid = 1'b0;
        checkIdle("vFF done");
        checkOutput("vFF empty", 32'(emptyDone), 32'd0);
        applyStimulus();
        checkIdle("vFF settled");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
